// File: rtl/retire_stage.sv
// ---------------------------------------------------------------------------
// retire_stage
//
// In-order commit stage. Takes the retire packet at the head of the ROB,
// commits architectural state (arch map table write, free-list return),
// performs stores at commit through a request/ack handshake, raises a
// pipeline flush on a taken branch (fetch predicts not-taken) and parks in
// a halted state once a halt instruction commits.
//
// Optional feature macro: RETIRE_PERF_CNT_EN
//   defined   -> perf_retired / perf_mispred / perf_store_stall count
//                commits, flushes and store-wait cycles
//   undefined -> the three counter outputs are tied to zero
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   retire_en             ROB head completed and valid
//   retire_t/_old         {valid, phys_reg} new and previous mapping of dest
//   inst, halt, wr_mem    head instruction, halt flag, store flag
//   dest_reg_idx          architectural destination
//   NPC, result           head PC+4, ALU result / store addr / branch target
//   rs2_value             store data
//   take_branch           head branch resolved taken
//   ir_stall              ROB must hold head this cycle
//   amt_wr_*              arch map table write port
//   fl_push_*             free-list return port
//   mem_req/addr/data/size, mem_ack   store handshake
//   flush, redirect_pc    pipeline squash and new fetch target
//   halted                halt has committed
//   retire_valid/pc       one instruction committed this cycle and its PC
//   perf_*                performance counters
// ---------------------------------------------------------------------------
module retire_stage #(
   parameter  int XLEN        = 32,
   parameter  int PHYS_REG_SZ = 64,
   localparam int TAG_W       = $clog2(PHYS_REG_SZ)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             retire_en,
   input  logic [TAG_W:0]   retire_t,
   input  logic [TAG_W:0]   retire_t_old,
   input  logic [31:0]      inst,
   input  logic             halt,
   input  logic             wr_mem,
   input  logic [4:0]       dest_reg_idx,
   input  logic [XLEN-1:0]  NPC,
   input  logic [XLEN-1:0]  result,
   input  logic [XLEN-1:0]  rs2_value,
   input  logic             take_branch,
   output logic             ir_stall,
   output logic             amt_wr_en,
   output logic [4:0]       amt_wr_idx,
   output logic [TAG_W-1:0] amt_wr_tag,
   output logic             fl_push_en,
   output logic [TAG_W-1:0] fl_push_tag,
   output logic             mem_req,
   output logic [XLEN-1:0]  mem_addr,
   output logic [XLEN-1:0]  mem_data,
   output logic [1:0]       mem_size,
   input  logic             mem_ack,
   output logic             flush,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             halted,
   output logic             retire_valid,
   output logic [XLEN-1:0]  retire_pc,
   output logic [31:0]      perf_retired,
   output logic [31:0]      perf_mispred,
   output logic [31:0]      perf_store_stall
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      STORE_WAIT = 2'd1,
      HALTED     = 2'd2
   } retireState_e;

   retireState_e state_q, state_d;

   logic commit;
   logic destNonZero;
   logic unusedInstBits;

   // Only the size field of the instruction is needed here; the rest of the
   // word is folded into a deliberately unused signal.
   assign unusedInstBits = ^{inst[31:14], inst[11:0]};

   assign destNonZero = (dest_reg_idx != 5'd0);

   // State register. Reset is synchronous, so a reset taken while waiting
   // on a store simply drops back to RUN and the request falls next cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and all commit outputs. Everything is combinational so the
   // ROB sees ir_stall and the commit side effects in the same cycle.
   always_comb begin
      state_d      = state_q;
      ir_stall     = 1'b0;
      commit       = 1'b0;
      amt_wr_en    = 1'b0;
      amt_wr_idx   = 5'd0;
      amt_wr_tag   = '0;
      fl_push_en   = 1'b0;
      fl_push_tag  = '0;
      mem_req      = 1'b0;
      mem_addr     = '0;
      mem_data     = '0;
      mem_size     = 2'b00;
      flush        = 1'b0;
      redirect_pc  = '0;
      halted       = 1'b0;
      retire_valid = 1'b0;
      retire_pc    = '0;

      unique case (state_q)
         RUN: begin
            if (retire_en && wr_mem) begin
               mem_req  = 1'b1;
               ir_stall = !mem_ack;
               if (!mem_ack) begin
                  state_d = STORE_WAIT;
               end
            end
         end
         STORE_WAIT: begin
            // The ROB keeps the head stable, so the request simply tracks it.
            mem_req  = 1'b1;
            ir_stall = !mem_ack;
            if (mem_ack) begin
               state_d = RUN;
            end
         end
         HALTED: begin
            halted   = 1'b1;
            ir_stall = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (mem_req) begin
         mem_addr = result;
         mem_data = rs2_value;
         mem_size = inst[13:12];
      end

      commit = retire_en && !ir_stall;

      if (commit) begin
         retire_valid = 1'b1;
         retire_pc    = NPC - XLEN'(4);

         // Stores never touch the rename state.
         if (!wr_mem) begin
            amt_wr_en  = retire_t[TAG_W] && destNonZero;
            fl_push_en = retire_t_old[TAG_W] && destNonZero;
            if (amt_wr_en) begin
               amt_wr_idx = dest_reg_idx;
               amt_wr_tag = retire_t[TAG_W-1:0];
            end
            if (fl_push_en) begin
               fl_push_tag = retire_t_old[TAG_W-1:0];
            end
         end

         // A halt outranks a taken branch: nothing after it will be fetched
         // anyway, so there is nothing to redirect.
         if (halt) begin
            state_d = HALTED;
         end else if (take_branch && !wr_mem) begin
            flush       = 1'b1;
            redirect_pc = result;
         end
      end
   end

`ifdef RETIRE_PERF_CNT_EN
   logic [31:0] perfRetired_q;
   logic [31:0] perfMispred_q;
   logic [31:0] perfStoreStall_q;

   // Free-running wrapping counters, frozen once the core has halted.
   always_ff @(posedge clock) begin
      if (reset) begin
         perfRetired_q    <= 32'd0;
         perfMispred_q    <= 32'd0;
         perfStoreStall_q <= 32'd0;
      end else if (state_q != HALTED) begin
         if (commit) begin
            perfRetired_q <= perfRetired_q + 32'd1;
         end
         if (flush) begin
            perfMispred_q <= perfMispred_q + 32'd1;
         end
         if (state_q == STORE_WAIT) begin
            perfStoreStall_q <= perfStoreStall_q + 32'd1;
         end
      end
   end

   assign perf_retired     = perfRetired_q;
   assign perf_mispred     = perfMispred_q;
   assign perf_store_stall = perfStoreStall_q;
`else
   assign perf_retired     = 32'd0;
   assign perf_mispred     = 32'd0;
   assign perf_store_stall = 32'd0;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// ---------------------------------------------------------------------------
// tb_retire_stage
//
// Directed bench for retire_stage. Inputs change 1 time unit after the
// rising clock edge and outputs are compared 1 unit later, well clear of
// the next edge. Expected values are written out by hand for each vector.
// Counter checks follow RETIRE_PERF_CNT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_retire_stage;

   localparam int XLEN  = 32;
   localparam int TAG_W = 6;

   logic             clock;
   logic             reset;
   logic             retire_en;
   logic [TAG_W:0]   retire_t;
   logic [TAG_W:0]   retire_t_old;
   logic [31:0]      inst;
   logic             halt;
   logic             wr_mem;
   logic [4:0]       dest_reg_idx;
   logic [XLEN-1:0]  NPC;
   logic [XLEN-1:0]  result;
   logic [XLEN-1:0]  rs2_value;
   logic             take_branch;
   logic             ir_stall;
   logic             amt_wr_en;
   logic [4:0]       amt_wr_idx;
   logic [TAG_W-1:0] amt_wr_tag;
   logic             fl_push_en;
   logic [TAG_W-1:0] fl_push_tag;
   logic             mem_req;
   logic [XLEN-1:0]  mem_addr;
   logic [XLEN-1:0]  mem_data;
   logic [1:0]       mem_size;
   logic             mem_ack;
   logic             flush;
   logic [XLEN-1:0]  redirect_pc;
   logic             halted;
   logic             retire_valid;
   logic [XLEN-1:0]  retire_pc;
   logic [31:0]      perf_retired;
   logic [31:0]      perf_mispred;
   logic [31:0]      perf_store_stall;

   int vectorCount = 0;
   int missCount   = 0;

   retire_stage #(.XLEN(XLEN), .PHYS_REG_SZ(64)) dut (
      .clock            (clock),
      .reset            (reset),
      .retire_en        (retire_en),
      .retire_t         (retire_t),
      .retire_t_old     (retire_t_old),
      .inst             (inst),
      .halt             (halt),
      .wr_mem           (wr_mem),
      .dest_reg_idx     (dest_reg_idx),
      .NPC              (NPC),
      .result           (result),
      .rs2_value        (rs2_value),
      .take_branch      (take_branch),
      .ir_stall         (ir_stall),
      .amt_wr_en        (amt_wr_en),
      .amt_wr_idx       (amt_wr_idx),
      .amt_wr_tag       (amt_wr_tag),
      .fl_push_en       (fl_push_en),
      .fl_push_tag      (fl_push_tag),
      .mem_req          (mem_req),
      .mem_addr         (mem_addr),
      .mem_data         (mem_data),
      .mem_size         (mem_size),
      .mem_ack          (mem_ack),
      .flush            (flush),
      .redirect_pc      (redirect_pc),
      .halted           (halted),
      .retire_valid     (retire_valid),
      .retire_pc        (retire_pc),
      .perf_retired     (perf_retired),
      .perf_mispred     (perf_mispred),
      .perf_store_stall (perf_store_stall)
   );

   // 10-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One comparison: counts it and reports a miscompare.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectorCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one full set of head inputs, then let the combinational outputs settle.
   task automatic applyStimulus(input logic en, input logic [TAG_W:0] t, input logic [TAG_W:0] tOld,
                                input logic [4:0] dest, input logic [31:0] npc, input logic [31:0] res,
                                input logic st, input logic ack, input logic br, input logic hlt);
      retire_en    = en;
      retire_t     = t;
      retire_t_old = tOld;
      dest_reg_idx = dest;
      NPC          = npc;
      result       = res;
      wr_mem       = st;
      mem_ack      = ack;
      take_branch  = br;
      halt         = hlt;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkCounters(input string tag, input int ret, input int mis, input int stl);
`ifdef RETIRE_PERF_CNT_EN
      checkOutput({tag, "_retired"}, 64'(perf_retired), 64'(ret));
      checkOutput({tag, "_mispred"}, 64'(perf_mispred), 64'(mis));
      checkOutput({tag, "_stall"}, 64'(perf_store_stall), 64'(stl));
`else
      checkOutput({tag, "_retired"}, 64'(perf_retired), 64'd0);
      checkOutput({tag, "_mispred"}, 64'(perf_mispred), 64'd0);
      checkOutput({tag, "_stall"}, 64'(perf_store_stall), 64'd0);
      if (ret + mis + stl < 0) $display("[TB] unreachable");
`endif
   endtask

   initial begin
      reset     = 1'b1;
      inst      = 32'h0000_2023;  // size field [13:12] = 2'b10 (word)
      rs2_value = 32'h0000_DEAD;
      applyStimulus(0, 7'h00, 7'h00, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;

      // Reset state
      checkOutput("rst_stall", 64'(ir_stall), 64'd0);
      checkOutput("rst_halted", 64'(halted), 64'd0);
      checkOutput("rst_memreq", 64'(mem_req), 64'd0);
      checkOutput("rst_valid", 64'(retire_valid), 64'd0);
      checkCounters("rst", 0, 0, 0);

      // ALU commit: t={1,12}, t_old={1,5}, dest=3
      applyStimulus(1, {1'b1, 6'd12}, {1'b1, 6'd5}, 5'd3, 32'h104, 32'h55, 0, 0, 0, 0);
      checkOutput("alu_amt_en", 64'(amt_wr_en), 64'd1);
      checkOutput("alu_amt_idx", 64'(amt_wr_idx), 64'd3);
      checkOutput("alu_amt_tag", 64'(amt_wr_tag), 64'd12);
      checkOutput("alu_fl_en", 64'(fl_push_en), 64'd1);
      checkOutput("alu_fl_tag", 64'(fl_push_tag), 64'd5);
      checkOutput("alu_stall", 64'(ir_stall), 64'd0);
      checkOutput("alu_valid", 64'(retire_valid), 64'd1);
      checkOutput("alu_pc", 64'(retire_pc), 64'h100);
      checkOutput("alu_flush", 64'(flush), 64'd0);
      tick();

      // dest=0 with valid tags: no rename side effects
      applyStimulus(1, {1'b1, 6'd12}, {1'b1, 6'd5}, 5'd0, 32'h108, 32'h0, 0, 0, 0, 0);
      checkOutput("d0_amt_en", 64'(amt_wr_en), 64'd0);
      checkOutput("d0_fl_en", 64'(fl_push_en), 64'd0);
      checkOutput("d0_valid", 64'(retire_valid), 64'd1);
      tick();

      // New tag invalid, old tag valid: free-list only
      applyStimulus(1, {1'b0, 6'd9}, {1'b1, 6'd33}, 5'd7, 32'h10C, 32'h0, 0, 0, 0, 0);
      checkOutput("tinv_amt_en", 64'(amt_wr_en), 64'd0);
      checkOutput("tinv_fl_en", 64'(fl_push_en), 64'd1);
      checkOutput("tinv_fl_tag", 64'(fl_push_tag), 64'd33);
      tick();

      // Idle
      applyStimulus(0, {1'b1, 6'd12}, {1'b1, 6'd5}, 5'd3, 32'h110, 32'h0, 0, 0, 0, 0);
      checkOutput("idle_valid", 64'(retire_valid), 64'd0);
      checkOutput("idle_stall", 64'(ir_stall), 64'd0);
      checkOutput("idle_amt_en", 64'(amt_wr_en), 64'd0);
      tick();
      checkCounters("alu", 3, 0, 0);

      // Store acked in the 4th cycle
      for (int c = 1; c <= 4; c++) begin
         applyStimulus(1, {1'b1, 6'd20}, {1'b1, 6'd21}, 5'd4, 32'h204, 32'h100, 1, (c == 4), 0, 0);
         checkOutput($sformatf("st%0d_req", c), 64'(mem_req), 64'd1);
         checkOutput($sformatf("st%0d_addr", c), 64'(mem_addr), 64'h100);
         checkOutput($sformatf("st%0d_data", c), 64'(mem_data), 64'hDEAD);
         checkOutput($sformatf("st%0d_size", c), 64'(mem_size), 64'd2);
         checkOutput($sformatf("st%0d_stall", c), 64'(ir_stall), (c < 4) ? 64'd1 : 64'd0);
         checkOutput($sformatf("st%0d_valid", c), 64'(retire_valid), (c == 4) ? 64'd1 : 64'd0);
         checkOutput($sformatf("st%0d_amt", c), 64'(amt_wr_en), 64'd0);
         checkOutput($sformatf("st%0d_fl", c), 64'(fl_push_en), 64'd0);
         tick();
      end
      applyStimulus(0, 7'h00, 7'h00, 5'd0, 32'h208, 32'h0, 0, 0, 0, 0);
      checkOutput("st_done_req", 64'(mem_req), 64'd0);
      checkOutput("st_done_stall", 64'(ir_stall), 64'd0);
      checkCounters("st", 4, 0, 3);

      // Store acked in the same cycle: no stall
      applyStimulus(1, 7'h00, 7'h00, 5'd0, 32'h20C, 32'h180, 1, 1, 0, 0);
      checkOutput("stq_req", 64'(mem_req), 64'd1);
      checkOutput("stq_stall", 64'(ir_stall), 64'd0);
      checkOutput("stq_valid", 64'(retire_valid), 64'd1);
      tick();
      applyStimulus(0, 7'h00, 7'h00, 5'd0, 32'h210, 32'h0, 0, 0, 0, 0);
      checkOutput("stq_after_req", 64'(mem_req), 64'd0);
      checkCounters("stq", 5, 0, 3);

      // Taken branch: flush for one cycle, redirect to result
      applyStimulus(1, 7'h00, 7'h00, 5'd0, 32'h40, 32'h2000, 0, 0, 1, 0);
      checkOutput("br_flush", 64'(flush), 64'd1);
      checkOutput("br_redirect", 64'(redirect_pc), 64'h2000);
      checkOutput("br_pc", 64'(retire_pc), 64'h3C);
      checkOutput("br_valid", 64'(retire_valid), 64'd1);
      tick();
      applyStimulus(0, 7'h00, 7'h00, 5'd0, 32'h40, 32'h2000, 0, 0, 0, 0);
      checkOutput("br_after_flush", 64'(flush), 64'd0);
      checkOutput("br_after_redirect", 64'(redirect_pc), 64'd0);
      checkCounters("br", 6, 1, 3);

      // retire_pc wraps below zero
      applyStimulus(1, 7'h00, 7'h00, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0);
      checkOutput("wrap_pc", 64'(retire_pc), 64'hFFFF_FFFC);
      tick();

      // Halt together with a taken branch: halt wins, no flush
      applyStimulus(1, 7'h00, 7'h00, 5'd0, 32'h84, 32'h3000, 0, 0, 1, 1);
      checkOutput("hlt_valid", 64'(retire_valid), 64'd1);
      checkOutput("hlt_flush", 64'(flush), 64'd0);
      checkOutput("hlt_pc", 64'(retire_pc), 64'h80);
      tick();

      // HALTED ignores a head held valid, including a store
      for (int c = 1; c <= 5; c++) begin
         applyStimulus(1, {1'b1, 6'd40}, {1'b1, 6'd41}, 5'd9, 32'h90, 32'h400, (c == 3), 0, 0, 0);
         checkOutput($sformatf("h%0d_halted", c), 64'(halted), 64'd1);
         checkOutput($sformatf("h%0d_stall", c), 64'(ir_stall), 64'd1);
         checkOutput($sformatf("h%0d_amt", c), 64'(amt_wr_en), 64'd0);
         checkOutput($sformatf("h%0d_fl", c), 64'(fl_push_en), 64'd0);
         checkOutput($sformatf("h%0d_valid", c), 64'(retire_valid), 64'd0);
         checkOutput($sformatf("h%0d_req", c), 64'(mem_req), 64'd0);
         tick();
      end
      checkCounters("halt", 8, 1, 3);

      // Reset leaves HALTED
      applyStimulus(0, 7'h00, 7'h00, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checkOutput("unhalt_halted", 64'(halted), 64'd0);
      checkOutput("unhalt_stall", 64'(ir_stall), 64'd0);
      checkCounters("unhalt", 0, 0, 0);

      // Reset in STORE_WAIT: request drops after the reset edge
      applyStimulus(1, 7'h00, 7'h00, 5'd0, 32'h304, 32'h500, 1, 0, 0, 0);
      tick();
      applyStimulus(1, 7'h00, 7'h00, 5'd0, 32'h304, 32'h500, 1, 0, 0, 0);
      checkOutput("sw_wait_stall", 64'(ir_stall), 64'd1);
      checkOutput("sw_wait_req", 64'(mem_req), 64'd1);
      tick();
      applyStimulus(0, 7'h00, 7'h00, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      checkOutput("sw_prerst_req", 64'(mem_req), 64'd1);
      tick();
      checkOutput("sw_rst_req", 64'(mem_req), 64'd0);
      checkOutput("sw_rst_stall", 64'(ir_stall), 64'd0);
      checkOutput("sw_rst_valid", 64'(retire_valid), 64'd0);
      reset = 1'b0;
      tick();
      checkCounters("sw_rst", 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- In-order commit (IR) stage; consumes the ROB head retire packet and drives `ir_stall` back to the ROB.
- Commits architectural state: writes the arch map table and returns old physical tags to the free list.
- Performs stores at commit through a memory request/ack handshake.
- Raises the pipeline flush on a taken branch (predict-not-taken) and enters a halted state on a halt instruction.

Parameters:
- XLEN, 32, data/address width.
- PHYS_REG_SZ, 64, number of physical registers; TAG_W = $clog2(PHYS_REG_SZ).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- retire_en  in  1  ROB head completed and valid
- retire_t  in  TAG_W+1  {valid, phys_reg} new tag of head
- retire_t_old  in  TAG_W+1  {valid, phys_reg} previous mapping of dest
- inst  in  32  head instruction
- halt  in  1  head is halt
- wr_mem  in  1  head is store
- dest_reg_idx  in  5  architectural destination
- NPC  in  XLEN  head PC+4
- result  in  XLEN  ALU result / store address / branch target
- rs2_value  in  XLEN  store data
- take_branch  in  1  head branch resolved taken
- ir_stall  out  1  ROB must hold head this cycle
- amt_wr_en  out  1  arch map write
- amt_wr_idx  out  5  arch register
- amt_wr_tag  out  TAG_W  physical register
- fl_push_en  out  1  free-list return
- fl_push_tag  out  TAG_W  freed physical register
- mem_req  out  1  store request, level, held until ack
- mem_addr  out  XLEN  = result
- mem_data  out  XLEN  = rs2_value
- mem_size  out  2  = inst[13:12] (byte/half/word)
- mem_ack  in  1  store accepted this cycle
- flush  out  1  squash pipeline; drives ROB interrupt
- redirect_pc  out  XLEN  fetch target on flush
- halted  out  1  halt committed
- retire_valid  out  1  one instruction committed this cycle
- retire_pc  out  XLEN  NPC-4 of committed instruction
- perf_retired, perf_mispred, perf_store_stall  out  32 each  performance counters

Behaviour:
- FSM states: RUN, STORE_WAIT, HALTED. Reset: RUN; all outputs 0 except `ir_stall`=0.
- Commit condition: `commit = retire_en && !ir_stall`. All commit outputs are combinational in the commit cycle. At most one commit per cycle.
- RUN, head not store, `retire_en`=1:
  - `ir_stall`=0; commit.
  - `amt_wr_en` = `retire_t.valid` && `dest_reg_idx`!=0.
  - `fl_push_en` = `retire_t_old.valid` && `dest_reg_idx`!=0.
  - `retire_valid`=1.
- RUN, head store (`retire_en` && `wr_mem`):
  - `mem_req`=1.
  - If `mem_ack` is high the same cycle: commit, stay in RUN.
  - Otherwise: `ir_stall`=1, go to STORE_WAIT.
- STORE_WAIT:
  - `mem_req`=1; address/data/size track head inputs (the ROB holds the head stable).
  - `ir_stall`=1 until `mem_ack`.
  - On `mem_ack`: `ir_stall`=0, commit, return to RUN. A store never writes amt/fl.
- Taken branch commit (`take_branch`=1):
  - `flush`=1 and `redirect_pc`=`result` in the same cycle as the commit; single-cycle pulse.
  - Next cycle ROB is empty; `retire_en`=0 is expected.
- Halt commit:
  - `retire_valid`=1 in the commit cycle; then HALTED.
  - HALTED: `halted`=1, `ir_stall`=1, `retire_en` ignored, no outputs asserted except `halted`/`ir_stall`; exit only via reset.
- `retire_en`=0 in RUN: `ir_stall`=0; all commit outputs 0.
- Simultaneous cases:
  - Halt and take_branch both set: halt wins, no flush.
  - Store with take_branch: not legal, no check.
- Reset mid-STORE_WAIT: return to RUN, `mem_req` drops in the cycle after the reset edge; no commit.
- `retire_pc` = `NPC` - 4, modulo 2^XLEN.

Optional Feature:
- Macro `RETIRE_PERF_CNT_EN`.
- Defined:
  - `perf_retired` += 1 per commit.
  - `perf_mispred` += 1 per flush.
  - `perf_store_stall` += 1 per STORE_WAIT cycle.
  - Counters are 32-bit wrapping, reset to 0, frozen in HALTED.
- Undefined: all three outputs tied 0; no counter flops.

Test Plan:
- ALU commit: `retire_en`=1, t={1,12}, t_old={1,5}, dest=3 -> `amt_wr_en`=1 (idx 3, tag 12), `fl_push_en`=1 (tag 5), `ir_stall`=0, `retire_valid`=1.
- dest=0 with valid tags -> `amt_wr_en`=0, `fl_push_en`=0, `retire_valid`=1.
- Store, `mem_ack` after 3 cycles, result=0x100, rs2=0xDEAD -> `mem_req`=1 for 4 cycles with addr 0x100 / data 0xDEAD; `ir_stall`=1 for 3 cycles; commit in cycle 4; `perf_store_stall`=3 if enabled.
- Taken branch, result=0x2000, NPC=0x40 -> `flush`=1 for exactly 1 cycle, `redirect_pc`=0x2000, `retire_pc`=0x3C.
- Halt, then `retire_en` held 1 for 5 cycles -> `halted`=1, `ir_stall`=1, no amt/fl/`retire_valid` after the halt cycle; reset -> RUN, `halted`=0.
- Reset asserted in STORE_WAIT -> next cycle `mem_req`=0, state RUN, counters 0.
